// File: rtl/mux_gate_scheduler.sv
// mux_gate_scheduler: round-robin access to a single bit-serial 2:1 mux logic
// cell. A granted requester's opcode and operands are latched. The selected
// boolean operation is then evaluated LSB first, one bit per cycle, through
// the mux. The W-bit result is published together with a one-cycle done pulse.
module mux_gate_scheduler #(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [3*N-1:0]   op,
  input  logic [W*N-1:0]   a,
  input  logic [W*N-1:0]   b,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             done,
  output logic [IDW-1:0]   done_id,
  output logic [W-1:0]     result,
  output logic             err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick_id;
  logic           pick_valid;
  logic           take;
  logic [IDW-1:0] cur_id;
  logic [2:0]     cur_op;
  logic [W-1:0]   cur_a, cur_b;
  logic [W-1:0]   work, work_nxt;
  logic [CW-1:0]  cnt;
  logic           last_bit;
  logic           cell_out;
  logic           op_bad;
  logic           d0, d1;

  assign last_bit = (cnt == CW'(W - 1));
  assign take     = (state == S_IDLE) && pick_valid;

  // Round-robin pick: first set request at or above ptr, wrapping around
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  // Grant pulse in the IDLE cycle that accepts the request; suppressed in reset
  always_comb begin
    gnt = '0;
    if (take && !rst) gnt = N'(1) << pick_id;
  end

  // Mux cell: a[k] selects between two data legs chosen by the opcode
  always_comb begin
    d0     = 1'b0;
    d1     = 1'b0;
    op_bad = 1'b0;
    case (cur_op)
      3'd0: begin d1 = cur_b[cnt];  d0 = 1'b0;        end
      3'd1: begin d1 = 1'b1;        d0 = cur_b[cnt];  end
      3'd2: begin d1 = ~cur_b[cnt]; d0 = 1'b1;        end
      3'd3: begin d1 = 1'b0;        d0 = ~cur_b[cnt]; end
      3'd4: begin d1 = ~cur_b[cnt]; d0 = cur_b[cnt];  end
      3'd5: begin d1 = cur_b[cnt];  d0 = ~cur_b[cnt]; end
      default: op_bad = 1'b1;
    endcase
    cell_out = cur_a[cnt] ? d1 : d0;
  end

  // Working word with the current bit merged in, so the last bit can be
  // published in the same edge that completes the sweep
  always_comb begin
    work_nxt      = work;
    work_nxt[cnt] = cell_out;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_valid) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, bit sweep and result publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      cur_id  <= '0;
      cur_op  <= '0;
      cur_a   <= '0;
      cur_b   <= '0;
      work    <= '0;
      cnt     <= '0;
      result  <= '0;
      err     <= 1'b0;
      done_id <= '0;
    end else begin
      if (take) begin
        cur_id <= pick_id;
        cur_op <= op[32'(pick_id) * 3 +: 3];
        cur_a  <= a[32'(pick_id) * W +: W];
        cur_b  <= b[32'(pick_id) * W +: W];
        ptr    <= (pick_id == IDW'(N - 1)) ? '0 : pick_id + 1'b1;
        cnt    <= '0;
      end
      if (state == S_RUN) begin
        work <= work_nxt;
        cnt  <= cnt + 1'b1;
        if (last_bit) begin
          result  <= op_bad ? '0 : work_nxt;
          err     <= op_bad;
          done_id <= cur_id;
        end
      end
    end
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mux_gate_scheduler.sv
// Bench for mux_gate_scheduler: table of directed ops, hand-written arbitration,
// invalid-op and reset sequences, then random traffic against a word-level model.
module tb_mux_gate_scheduler;
  localparam int W = 8, N = 4, IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [3*N-1:0]   op;
  logic [W*N-1:0]   a, b;
  logic [N-1:0]     gnt;
  logic             busy, done, err;
  logic [IDW-1:0]   done_id;
  logic [W-1:0]     result;

  mux_gate_scheduler #(.W(W), .N(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mptr = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word-level reference of the six boolean operations
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic e);
    e = 1'b0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = ~(x & y);
      3'd3: r = ~(x | y);
      3'd4: r = x ^ y;
      3'd5: r = ~(x ^ y);
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  function automatic int model_pick(input logic [N-1:0] m);
    for (int off = 0; off < N; off++)
      if (m[(mptr + off) % N]) return (mptr + off) % N;
    return 0;
  endfunction

  task automatic set_req(input int i, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op[3*i +: 3] = o;
    a[W*i +: W]  = x;
    b[W*i +: W]  = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mptr = 0;
  endtask

  // One transaction: checks grant, latency and done pulse; returns published outputs
  task automatic txn(input logic [N-1:0] mask, input bit scramble, output int id,
                     output logic [W-1:0] r, output logic e);
    int cyc;
    @(negedge clk);
    req = mask;
    #1;
    id = model_pick(mask);
    chk("gnt_onehot", gnt, 32'(1) << id);
    chk("busy_in_gnt", busy, 0);
    mptr = (id + 1) % N;
    @(negedge clk);
    req = '0;
    if (scramble) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op = 12'($urandom);
    end
    chk("busy_run", busy, 1);
    chk("gnt_drop", gnt, 0);
    cyc = 1;
    while (!done && cyc < 3 * W) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc, W + 1);
    chk("done_id", done_id, id);
    r = result;
    e = err;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("result_held", result, r);
    chk("busy_idle", busy, 0);
  endtask

  vec_t vecs[8];
  int   id;
  logic [W-1:0] r, er;
  logic e, ee;
  logic [3*N-1:0] op_s;
  logic [W*N-1:0] a_s, b_s;

  initial begin
    vecs[0] = '{3'd0, 8'hCA, 8'hA6, 8'h82, 1'b0};
    vecs[1] = '{3'd1, 8'hCA, 8'hA6, 8'hEE, 1'b0};
    vecs[2] = '{3'd2, 8'hCA, 8'hA6, 8'h7D, 1'b0};
    vecs[3] = '{3'd3, 8'hCA, 8'hA6, 8'h11, 1'b0};
    vecs[4] = '{3'd4, 8'hCA, 8'hA6, 8'h6C, 1'b0};
    vecs[5] = '{3'd5, 8'hCA, 8'hA6, 8'h93, 1'b0};
    vecs[6] = '{3'd4, 8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[7] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1};

    rst = 1'b1; req = '0; op = '0; a = '0; b = '0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_done_id", done_id, 0);
    do_reset();

    // Directed table on requester 0
    for (int i = 0; i < 8; i++) begin
      set_req(0, vecs[i].op, vecs[i].a, vecs[i].b);
      txn(4'b0001, 1'b0, id, r, e);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_err", i), e, vecs[i].err);
    end

    // Invalid opcode on requester 2, then a valid op clears err
    set_req(2, 3'd6, 8'h5A, 8'h3C);
    txn(4'b0100, 1'b0, id, r, e);
    chk("inv_result", r, 0);
    chk("inv_err", e, 1);
    chk("inv_id", id, 2);
    set_req(2, 3'd1, 8'h5A, 8'h3C);
    txn(4'b0100, 1'b0, id, r, e);
    chk("inv_next_result", r, 8'h7E);
    chk("inv_next_err", e, 0);

    // All four requests held from reset: grants 0,1,2,3,0 every W+2 cycles
    begin
      int gcount, last_t, gi;
      gcount = 0; last_t = 0;
      @(negedge clk);
      rst = 1'b1;
      req = 4'hF;
      for (int i = 0; i < N; i++) set_req(i, 3'd0, 8'($urandom), 8'($urandom));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int t = 0; t < 60 && gcount < 5; t++) begin
        if (gnt != 0) begin
          gi = 0;
          for (int k = 0; k < N; k++) if (gnt[k]) gi = k;
          chk("rr_onehot", $countones(gnt), 1);
          chk("rr_order", gi, gcount % N);
          chk("rr_no_done", done, 0);
          if (gcount > 0) chk("rr_spacing", t - last_t, W + 2);
          last_t = t;
          gcount++;
        end
        @(negedge clk);
        #1;
      end
      chk("rr_count", gcount, 5);
      do_reset();
    end

    // Pointer wrap: after grant to 3, requests 1 and 2 together go 1 then 2
    set_req(3, 3'd0, 8'hF0, 8'hFF);
    txn(4'b1000, 1'b0, id, r, e);
    chk("wrap_first", id, 3);
    set_req(1, 3'd1, 8'h01, 8'h02);
    set_req(2, 3'd1, 8'h04, 8'h08);
    txn(4'b0110, 1'b0, id, r, e);
    chk("wrap_pick1", id, 1);
    chk("wrap_res1", r, 8'h03);
    txn(4'b0100, 1'b0, id, r, e);
    chk("wrap_pick2", id, 2);
    chk("wrap_res2", r, 8'h0C);

    // Operands changed right after grant must not affect the result
    set_req(1, 3'd4, 8'h96, 8'h0F);
    txn(4'b0010, 1'b1, id, r, e);
    chk("scramble_result", r, 8'h99);

    // Reset during RUN at bit 4: outputs clear at once, no done, pending req regranted
    set_req(0, 3'd1, 8'h21, 8'h84);
    @(negedge clk);
    req = 4'b0001;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_id", done_id, 0);
    @(negedge clk);
    chk("mid_rst_hold_done", done, 0);
    rst = 1'b0;
    mptr = 0;
    #1;
    chk("post_rst_gnt", gnt, 4'b0001);
    begin
      int cyc;
      @(negedge clk);
      req = '0;
      cyc = 1;
      while (!done && cyc < 3 * W) begin
        @(negedge clk);
        cyc++;
      end
      chk("post_rst_latency", cyc, W + 1);
      chk("post_rst_result", result, 8'hA5);
      mptr = 1;
    end

    // Random traffic against the word-level model
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      op_s = op; a_s = a; b_s = b;
      txn(4'($urandom_range(1, 15)), 1'($urandom), id, r, e);
      model(op_s[3*id +: 3], a_s[W*id +: W], b_s[W*id +: W], er, ee);
      chk("rand_result", r, er);
      chk("rand_err", e, ee);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
